prod_accumulator: RTL and testbench
===================================

# prod_accumulator

Sequential accumulate stage directly downstream of the team's 4-bit combinational multiplier. It consumes the multiplier's 8-bit products through a valid/ready handshake and sums a block of `COUNT` products, or fewer if the block is ended early with `in_last`. It then presents the block sum with an overflow flag through a second valid/ready handshake. This makes a 4-bit x 4-bit multiply-accumulate (dot-product) datapath when placed after the multiplier.

## Interface

Parameters:
- `ACC_W`, default 16: accumulator and result width; legal range 8..32.
- `COUNT`, default 4: products per block; legal range 1..255.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `in_valid`, input, 1: `in_prod` is valid this cycle.
- `in_ready`, output, 1: block can accept a product this cycle.
- `in_prod`, input, 8: unsigned product from the multiplier.
- `in_last`, input, 1: qualified by `in_valid`; this beat ends the block early.
- `out_valid`, output, 1: `out_sum` / `out_ovf` / `out_cnt` are valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, `ACC_W`: block sum.
- `out_ovf`, output, 1: overflow occurred at least once in this block (sticky per block).
- `out_cnt`, output, 8: number of products summed in this block (1..`COUNT`).

## Operation

- FSM has two states, both registered:
  - `ACC`: `in_ready`=1, `out_valid`=0.
  - `HOLD`: `in_ready`=0, `out_valid`=1.
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from `in_valid` or `out_ready`.
- Accept condition: `in_valid && in_ready`. On accept:
  - acc <= acc + zero-extended `in_prod`, following the overflow rule below;
  - cnt <= cnt+1.
- Block end: an accepted beat where cnt+1 == `COUNT` or `in_last`=1. On block end:
  - move to `HOLD`;
  - `out_sum` = updated acc, `out_cnt` = cnt+1, `out_ovf` = sticky flag including this beat.
- In `HOLD`, when `out_ready`=1 the result is consumed. Then acc, cnt and the ovf flag clear to 0 and the state returns to `ACC`.
- `HOLD` with `out_ready`=0: all outputs stay stable and nothing is accepted.
- Overflow rule: unsigned sum exceeds 2^`ACC_W`−1. Default behaviour wraps modulo 2^`ACC_W` and sets the sticky flag (see Configuration).
- Counter reaching `COUNT` and `in_last` on the same beat counts as a single block end.
- `COUNT`=1: every accepted beat is a block end.

## Timing

- Reset (`rst_n`=0 at an edge): state=`ACC`, acc=0, cnt=0, ovf=0.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `out_cnt`=0.
- Reset mid-block or in `HOLD`: the partial sum or pending result is discarded with no output.
- Latency: `out_valid` rises on the cycle after the block-ending beat is accepted.
- Throughput: one product per cycle within a block, plus a minimum one-cycle `HOLD` bubble per block.
  - With `out_ready` tied to 1, a block of N beats takes N+1 cycles.
- `out_valid` is never deasserted without a handshake, except by reset.
- `out_*` are registered outputs and hold their value while `out_valid`=0 is not guaranteed. The consumer must qualify them with `out_valid`.

## Configuration

- `PROD_ACC_SAT_EN` defined: on overflow, acc clamps to 2^`ACC_W`−1 and stays there for the rest of the block. The `ovf` flag is still set.
- `PROD_ACC_SAT_EN` undefined: acc wraps modulo 2^`ACC_W` and the `ovf` flag is set.
- All other behaviour is identical in both configurations.

## Test plan

- Reset then idle: after `rst_n` low for 2 cycles, expect `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_cnt`=0.
- Full block, `COUNT`=4, `ACC_W`=16: products 225, 225, 225, 225 back-to-back with `out_ready`=1.
  - Expect `out_sum`=900 (0x0384), `out_cnt`=4, `out_ovf`=0, `out_valid` for exactly 1 cycle.
  - The next block starts from 0.
- Early end: `in_prod` 6, then 10 with `in_last`=1.
  - Expect `out_sum`=16, `out_cnt`=2.
  - `in_valid` during `HOLD` is not accepted; the product is held upstream and lands in the next block.
- Backpressure: `out_ready`=0 for 5 cycles in `HOLD`.
  - `out_valid`/`out_sum` stay stable and `in_ready`=0 throughout.
  - Release `out_ready`; `in_ready`=1 on the following cycle.
- Overflow, `ACC_W`=10, `COUNT`=8, eight products of 225 (true sum 1800):
  - without `PROD_ACC_SAT_EN`: `out_sum`=776, `out_ovf`=1;
  - with `PROD_ACC_SAT_EN`: `out_sum`=1023, `out_ovf`=1.
- Reset mid-block: accept 2 beats, assert `rst_n`=0 for one cycle, then send 4 beats of 1.
  - Expect `out_sum`=4, `out_cnt`=4.

Source files
------------

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums blocks of 8-bit products (COUNT beats or in_last) and hands out sum/ovf/cnt.
// Optional PROD_ACC_SAT_EN: clamp accumulator at all-ones on overflow instead of wrapping.
module prod_accumulator #(
  parameter int ACC_W = 16,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [7:0]       out_cnt
);
  localparam logic [0:0] ACC  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic [7:0]       cnt_inc;
  logic             acc_en, blk_end;
  always_comb begin
    acc_en  = in_valid && state_q == ACC;
    sum     = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, in_prod};
    cnt_inc = cnt_q + 8'd1;
    blk_end = cnt_inc == 8'(COUNT) || in_last;
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (acc_en) begin
`ifdef PROD_ACC_SAT_EN
      acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
      cnt_d   = cnt_inc;
      ovf_d   = ovf_q | sum[ACC_W];
      state_d = blk_end ? HOLD : ACC;
    end else if (state_q == HOLD && out_ready) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = ACC;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
  assign in_ready  = state_q == ACC;
  assign out_valid = state_q == HOLD;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_cnt   = cnt_q;
endmodule

// File: tb/tb_prod_accumulator.sv
// tb_prod_accumulator: directed plus random checks of prod_accumulator against a block-level model.
module tb_prod_accumulator;
  localparam int W = 16, C = 4, W2 = 10, C2 = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_prod = '0;
  logic in_ready, out_valid, out_ovf;
  logic [W-1:0] out_sum;
  logic [7:0] out_cnt;
  logic v2 = 1'b0, l2 = 1'b0, r2 = 1'b0;
  logic [7:0] p2 = '0;
  logic rdy2, val2, ovf2;
  logic [W2-1:0] sum2;
  logic [7:0] cnt2;
  prod_accumulator #(.ACC_W(W), .COUNT(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_cnt(out_cnt));
  prod_accumulator #(.ACC_W(W2), .COUNT(C2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_prod(p2),
    .in_last(l2), .out_valid(val2), .out_ready(r2), .out_sum(sum2),
    .out_ovf(ovf2), .out_cnt(cnt2));
  int checks = 0, errors = 0;
  int q[$];
  bit hold = 1'b0;
  longint e_sum;
  int e_cnt;
  bit e_ovf;
  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Block result derived from the list of accepted products, not from any running accumulator.
  task automatic close_block();
    longint total = 0;
    longint maxv = (longint'(1) << W) - 1;
    foreach (q[i]) total += q[i];
    hold  = 1'b1;
    e_cnt = q.size();
    e_ovf = total > maxv;
`ifdef PROD_ACC_SAT_EN
    e_sum = total > maxv ? maxv : total;
`else
    e_sum = total % (longint'(1) << W);
`endif
  endtask
  task automatic drive(bit v, logic [7:0] p, bit l, bit r);
    in_valid = v; in_prod = p; in_last = l; out_ready = r;
    if (!hold && v) begin
      q.push_back(int'(p));
      if (l || q.size() == C) close_block();
    end else if (hold && r) begin
      hold = 1'b0;
      q.delete();
    end
    @(posedge clk); #1;
    chk("in_ready", in_ready, !hold);
    chk("out_valid", out_valid, hold);
    if (hold) begin
      chk("out_sum", out_sum, e_sum);
      chk("out_cnt", out_cnt, e_cnt);
      chk("out_ovf", out_ovf, e_ovf);
    end
  endtask
  task automatic do_reset(int n);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    hold = 1'b0;
    q.delete();
  endtask
  initial begin
    do_reset(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_ovf", out_ovf, 0);
    repeat (4) drive(1, 8'd225, 0, 1);
    chk("full_sum", out_sum, 900);
    chk("full_cnt", out_cnt, 4);
    chk("full_ovf", out_ovf, 0);
    drive(0, 8'd0, 0, 1);
    chk("full_one_cycle", out_valid, 0);
    drive(1, 8'd6, 0, 1);
    drive(1, 8'd10, 1, 0);
    chk("early_sum", out_sum, 16);
    chk("early_cnt", out_cnt, 2);
    repeat (5) begin
      drive(1, 8'd99, 0, 0);
      chk("bp_sum", out_sum, 16);
      chk("bp_in_ready", in_ready, 0);
    end
    drive(1, 8'd99, 0, 1);
    chk("release_in_ready", in_ready, 1);
    drive(1, 8'd99, 1, 1);
    chk("held_beat_sum", out_sum, 99);
    chk("held_beat_cnt", out_cnt, 1);
    drive(0, 8'd0, 0, 1);
    repeat (2) drive(1, 8'd5, 0, 1);
    do_reset(1);
    repeat (4) drive(1, 8'd1, 0, 1);
    chk("midrst_sum", out_sum, 4);
    chk("midrst_cnt", out_cnt, 4);
    drive(0, 8'd0, 0, 1);
    repeat (500) drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
                       $urandom_range(0, 2) != 0);
    drive(0, 8'd0, 0, 1);
    drive(0, 8'd0, 0, 1);
    v2 = 1'b1; p2 = 8'd225; r2 = 1'b0;
    repeat (C2) @(posedge clk);
    #1 v2 = 1'b0;
    chk("ovf_valid", val2, 1);
    chk("ovf_cnt", cnt2, 8);
    chk("ovf_flag", ovf2, 1);
`ifdef PROD_ACC_SAT_EN
    chk("ovf_sum", sum2, 1023);
`else
    chk("ovf_sum", sum2, 1800 % 1024);
`endif
    r2 = 1'b1;
    @(posedge clk); #1;
    chk("ovf_consumed", val2, 0);
    chk("ovf_ready", rdy2, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
